// File: rtl/alert_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : alert_tx_sched (with pr_pkg)
// Description : Round-robin scheduler that sequences four-phase differential
//               alert handshakes for NumAlerts channels over one shared path,
//               with per-phase timeout and ack integrity checking.
// Revision    : 1.0 - initial release
// ============================================================================

package pr_pkg;
    typedef struct packed {
        logic alert_p;
        logic alert_n;
    } alert_tx_t;
endpackage

module alert_tx_sched #(
    parameter int NumAlerts     = 3,
    parameter int TimeoutCycles = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumAlerts-1:0]              alert_req_i,
    input  logic [NumAlerts-1:0]              ack_p_i,
    input  logic [NumAlerts-1:0]              ack_n_i,
    output pr_pkg::alert_tx_t [NumAlerts-1:0] alert_tx_o,
    output logic                              busy_o,
    output logic [$clog2(NumAlerts)-1:0]      active_idx_o,
    output logic                              timeout_o,
    output logic                              integ_err_o
);

    localparam int IDX_W = $clog2(NumAlerts);
    localparam int CNT_W = $clog2(TimeoutCycles + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NumAlerts - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TimeoutCycles - 1);
    localparam pr_pkg::alert_tx_t DRV_ON   = '{alert_p: 1'b1, alert_n: 1'b0};
    localparam pr_pkg::alert_tx_t DRV_OFF  = '{alert_p: 1'b0, alert_n: 1'b1};
    localparam logic [2*NumAlerts-1:0] ALL_IDLE = {NumAlerts{2'b01}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSERT   = 2'd1,
        ST_DEASSERT = 2'd2
    } state_t;

    state_t                              state;
    logic [NumAlerts-1:0]                pending;
    logic [IDX_W-1:0]                    ptr;
    logic [IDX_W-1:0]                    active_idx;
    logic [CNT_W-1:0]                    cnt;
    pr_pkg::alert_tx_t [NumAlerts-1:0]   alert_tx;
    logic                                busy;
    logic                                timeout;
    logic                                integ_err;

    logic [IDX_W-1:0]                    lo_win;
    logic [IDX_W-1:0]                    hi_win;
    logic                                hi_found;
    logic [IDX_W-1:0]                    winner;
    logic                                any_pending;
    logic                                grant;
    logic [NumAlerts-1:0]                grant_mask;
    logic                                ack_p_sel;
    logic                                ack_n_sel;
    logic                                ack_on;
    logic                                ack_off;
    logic                                ack_bad;
    logic                                phase_last;
    logic [CNT_W-1:0]                    cnt_inc;

    // Round-robin pick: lowest pending index at or above ptr, else lowest pending overall (wrap)
    always_comb begin
        lo_win   = '0;
        hi_win   = '0;
        hi_found = 1'b0;
        for (int i = NumAlerts - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lo_win = IDX_W'(i);
                if (IDX_W'(i) >= ptr) begin
                    hi_win   = IDX_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
    end

    assign winner      = hi_found ? hi_win : lo_win;
    assign any_pending = |pending;
    assign grant       = (state == ST_IDLE) && any_pending;

    // One-hot clear mask for the channel being granted this cycle
    for (genvar g = 0; g < NumAlerts; g++) begin : g_grant_mask
        assign grant_mask[g] = grant && (winner == IDX_W'(g));
    end

    // Ack decode for the granted channel only; other channels are ignored
    assign ack_p_sel  = ack_p_i[active_idx];
    assign ack_n_sel  = ack_n_i[active_idx];
    assign ack_on     = ack_p_sel & ~ack_n_sel;
    assign ack_off    = ~ack_p_sel & ack_n_sel;
    assign ack_bad    = (ack_p_sel == ack_n_sel);
    assign phase_last = (cnt == CNT_LAST);
    assign cnt_inc    = (cnt == '1) ? cnt : cnt + 1'b1;

    // Scheduler FSM: grant, drive the four-phase handshake, time out stuck phases
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            pending     <= '0;
            ptr         <= '0;
            active_idx  <= '0;
            cnt         <= '0;
            alert_tx    <= ALL_IDLE;
            busy        <= 1'b0;
            timeout     <= 1'b0;
            integ_err   <= 1'b0;
        end else begin
            timeout   <= 1'b0;
            integ_err <= 1'b0;
            // A new request wins over the grant clear so it is served in a later round
            pending   <= (pending & ~grant_mask) | alert_req_i;

            case (state)
                ST_IDLE: begin
                    if (any_pending) begin
                        state            <= ST_ASSERT;
                        active_idx       <= winner;
                        ptr              <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
                        cnt              <= '0;
                        busy             <= 1'b1;
                        alert_tx[winner] <= DRV_ON;
                    end
                end

                ST_ASSERT: begin
                    integ_err <= ack_bad;
                    if (ack_on) begin
                        state                <= ST_DEASSERT;
                        cnt                  <= '0;
                        alert_tx[active_idx] <= DRV_OFF;
                    end else if (phase_last) begin
                        state                <= ST_IDLE;
                        timeout              <= 1'b1;
                        busy                 <= 1'b0;
                        alert_tx[active_idx] <= DRV_OFF;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                ST_DEASSERT: begin
                    integ_err <= ack_bad;
                    if (ack_off) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (phase_last) begin
                        state   <= ST_IDLE;
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    alert_tx <= ALL_IDLE;
                end
            endcase
        end
    end

    assign alert_tx_o   = alert_tx;
    assign busy_o       = busy;
    assign active_idx_o = active_idx;
    assign timeout_o    = timeout;
    assign integ_err_o  = integ_err;

endmodule

`default_nettype wire

// File: tb/tb_alert_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_alert_tx_sched
// Description : Self-checking bench for alert_tx_sched: directed scenarios
//               plus randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alert_tx_sched;

    localparam int NA = 3;
    localparam int TC = 16;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [NA-1:0]              req;
    logic [NA-1:0]              ack_p;
    logic [NA-1:0]              ack_n;
    pr_pkg::alert_tx_t [NA-1:0] tx;
    logic                       busy;
    logic [1:0]                 idx;
    logic                       to;
    logic                       ie;

    int total = 0;
    int bad   = 0;

    // Event log filled in by tick
    bit         auto_ack;
    logic [5:0] prev_tx;
    logic       prev_busy;
    int         idle_run;
    int         grant_q[$];
    int         gap_q[$];
    int         to_cnt;
    int         ie_cnt;

    // Behavioural model state (phase: 0 idle, 1 waiting for ack, 2 waiting for release)
    int  m_phase, m_idx, m_ptr, m_age;
    bit  m_pend[NA];
    bit  e_to, e_ie;

    alert_tx_sched #(.NumAlerts(NA), .TimeoutCycles(TC)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .alert_req_i  (req),
        .ack_p_i      (ack_p),
        .ack_n_i      (ack_n),
        .alert_tx_o   (tx),
        .busy_o       (busy),
        .active_idx_o (idx),
        .timeout_o    (to),
        .integ_err_o  (ie)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Run-time bound
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got=timeout want=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (busy && !prev_busy) begin
            grant_q.push_back(int'(idx));
            gap_q.push_back(idle_run);
        end
        idle_run  = busy ? 0 : idle_run + 1;
        if (to) to_cnt++;
        if (ie) ie_cnt++;
        prev_busy = busy;
        // Responder: each ack rail copies its pair's drive with a one-cycle lag
        if (auto_ack) begin
            for (int i = 0; i < NA; i++) begin
                ack_p[i] = prev_tx[2*i+1];
                ack_n[i] = prev_tx[2*i];
            end
        end
        prev_tx = tx;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clear_log();
        grant_q.delete();
        gap_q.delete();
        to_cnt = 0;
        ie_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req      = '0;
        ack_p    = '0;
        ack_n    = '1;
        auto_ack = 1'b0;
        prev_tx  = 6'b010101;
        tick();
        tick();
        rst_n     = 1'b1;
        prev_busy = 1'b0;
        idle_run  = 0;
        clear_log();
    endtask

    // Grant order encoded as decimal digits (channel+1) for compact comparison
    function automatic int order_code();
        int code = 0;
        foreach (grant_q[i]) code = code * 10 + grant_q[i] + 1;
        return code;
    endfunction

    task automatic test_reset();
        do_reset();
        total++;
        if ({busy, idx, to, ie} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=%b", {busy, idx, to, ie}, 5'b0);
        end
        total++;
        if (tx !== 6'b010101) begin
            bad++;
            $display("FAIL reset_tx got=%b want=%b", tx, 6'b010101);
        end
    endtask

    task automatic test_single();
        int n;
        do_reset();
        auto_ack = 1'b1;
        req = 3'b010;
        tick();
        req = '0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL single_early_busy got=%b want=0", busy);
        end
        tick();
        total++;
        if ({busy, idx} !== 3'b101) begin
            bad++;
            $display("FAIL single_grant got=%b want=%b", {busy, idx}, 3'b101);
        end
        total++;
        if (tx !== 6'b011001) begin
            bad++;
            $display("FAIL single_drive got=%b want=%b", tx, 6'b011001);
        end
        tick();
        total++;
        if (tx[1] !== 2'b10) begin
            bad++;
            $display("FAIL single_drive2 got=%b want=10", tx[1]);
        end
        n = 2;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (busy) n++;
            else break;
        end
        total++;
        if (n !== 4 || tx !== 6'b010101) begin
            bad++;
            $display("FAIL single_len got=%0d/%b want=4/%b", n, tx, 6'b010101);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        auto_ack = 1'b1;
        req = 3'b111;
        tick();
        req = '0;
        run(30);
        total++;
        if (order_code() !== 123) begin
            bad++;
            $display("FAIL fair_order got=%0d want=123", order_code());
        end
        total++;
        if (gap_q.size() !== 3 || gap_q[1] !== 1 || gap_q[2] !== 1) begin
            bad++;
            $display("FAIL fair_gap got_size=%0d want gaps of 1", gap_q.size());
        end
        clear_log();
        req = 3'b101;
        tick();
        req = '0;
        run(30);
        total++;
        if (order_code() !== 13) begin
            bad++;
            $display("FAIL fair_order2 got=%0d want=13", order_code());
        end
    endtask

    task automatic test_rerequest();
        do_reset();
        auto_ack = 1'b1;
        req = 3'b111;
        tick();
        req = 3'b001;
        tick();
        req = '0;
        run(40);
        total++;
        if (order_code() !== 1231) begin
            bad++;
            $display("FAIL rereq_order got=%0d want=1231", order_code());
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        req = 3'b011;
        tick();
        req = '0;
        tick();
        total++;
        if ({busy, idx} !== 3'b100) begin
            bad++;
            $display("FAIL to_grant got=%b want=%b", {busy, idx}, 3'b100);
        end
        n = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (busy) n++;
            else break;
        end
        total++;
        if (n !== TC) begin
            bad++;
            $display("FAIL to_len got=%0d want=%0d", n, TC);
        end
        total++;
        if (to !== 1'b1 || tx !== 6'b010101) begin
            bad++;
            $display("FAIL to_pulse got=%b/%b want=1/%b", to, tx, 6'b010101);
        end
        tick();
        total++;
        if ({to, busy, idx} !== 4'b0101) begin
            bad++;
            $display("FAIL to_next got=%b want=%b", {to, busy, idx}, 4'b0101);
        end
        run(25);
        total++;
        if (to_cnt !== 2 || grant_q.size() !== 2) begin
            bad++;
            $display("FAIL to_count got=%0d/%0d want=2/2", to_cnt, grant_q.size());
        end
    endtask

    task automatic test_integrity();
        do_reset();
        req = 3'b001;
        tick();
        req = '0;
        tick();
        ack_p[0] = 1'b1;
        ack_n[0] = 1'b1;
        tick();
        total++;
        if ({busy, ie} !== 2'b11) begin
            bad++;
            $display("FAIL integ_c1 got=%b want=11", {busy, ie});
        end
        tick();
        total++;
        if (ie !== 1'b1 || tx[0] !== 2'b10) begin
            bad++;
            $display("FAIL integ_c2 got=%b/%b want=1/10", ie, tx[0]);
        end
        ack_n[0] = 1'b0;
        tick();
        total++;
        if (ie !== 1'b0 || tx[0] !== 2'b01 || busy !== 1'b1) begin
            bad++;
            $display("FAIL integ_deassert got=%b/%b/%b want=0/01/1", ie, tx[0], busy);
        end
        ack_p[0] = 1'b0;
        ack_n[0] = 1'b1;
        tick();
        total++;
        if ({busy, to, ie_cnt == 2} !== 3'b001) begin
            bad++;
            $display("FAIL integ_done got=%b/%b/%0d want=0/0/2", busy, to, ie_cnt);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        auto_ack = 1'b1;
        req = 3'b110;
        tick();
        req = '0;
        tick();
        req = 3'b001;
        tick();
        req = '0;
        tick();
        total++;
        if ({busy, idx} !== 3'b101 || tx[1] !== 2'b01) begin
            bad++;
            $display("FAIL mid_pre got=%b/%b want=101/01", {busy, idx}, tx[1]);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if ({busy, idx, to, ie} !== 5'b0 || tx !== 6'b010101) begin
            bad++;
            $display("FAIL mid_reset got=%b/%b want=%b/%b", {busy, idx, to, ie}, tx, 5'b0, 6'b010101);
        end
        clear_log();
        run(20);
        total++;
        if (grant_q.size() !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_nogrant got=%0d want=0", grant_q.size());
        end
    endtask

    // Reference: apply the scheduling rules to one cycle of inputs
    task automatic model_step(input logic [NA-1:0] r, input logic [NA-1:0] ap,
                              input logic [NA-1:0] an);
        int  w;
        bit  want_p;
        e_to = 1'b0;
        e_ie = 1'b0;
        if (m_phase == 0) begin
            w = -1;
            for (int k = NA - 1; k >= 0; k--)
                if (m_pend[(m_ptr + k) % NA]) w = (m_ptr + k) % NA;
            if (w >= 0) begin
                m_pend[w] = 1'b0;
                m_ptr     = (w + 1) % NA;
                m_idx     = w;
                m_age     = 0;
                m_phase   = 1;
            end
        end else begin
            want_p = (m_phase == 1);
            if (ap[m_idx] == an[m_idx]) e_ie = 1'b1;
            if (ap[m_idx] == want_p && an[m_idx] != want_p) begin
                m_phase = (m_phase == 1) ? 2 : 0;
                m_age   = 0;
            end else if (m_age == TC - 1) begin
                e_to    = 1'b1;
                m_phase = 0;
            end else begin
                m_age++;
            end
        end
        for (int i = 0; i < NA; i++) if (r[i]) m_pend[i] = 1'b1;
    endtask

    task automatic test_random();
        logic [NA-1:0] r, ap, an;
        logic [10:0]   exp_v, got_v;
        logic [5:0]    exp_tx;
        int            sel;
        do_reset();
        m_phase = 0; m_idx = 0; m_ptr = 0; m_age = 0;
        e_to = 1'b0; e_ie = 1'b0;
        for (int i = 0; i < NA; i++) m_pend[i] = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            for (int i = 0; i < NA; i++) begin
                r[i] = ($urandom_range(0, 5) == 0);
                sel  = $urandom_range(0, 19);
                if (sel < 9)       begin ap[i] = 1'b1; an[i] = 1'b0; end
                else if (sel < 18) begin ap[i] = 1'b0; an[i] = 1'b1; end
                else if (sel == 18) begin ap[i] = 1'b0; an[i] = 1'b0; end
                else               begin ap[i] = 1'b1; an[i] = 1'b1; end
            end
            req   = r;
            ack_p = ap;
            ack_n = an;
            model_step(r, ap, an);
            tick();
            for (int i = 0; i < NA; i++)
                exp_tx[2*i +: 2] = (m_phase == 1 && i == m_idx) ? 2'b10 : 2'b01;
            exp_v = {m_phase != 0, 2'(m_idx), e_to, e_ie, exp_tx};
            got_v = {busy, idx, to, ie, tx};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b want=%b (busy,idx,to,ie,tx)", c, got_v, exp_v);
            end
        end
        req = '0;
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        ack_p    = '0;
        ack_n    = '1;
        auto_ack = 1'b0;
        prev_tx  = 6'b010101;
        prev_busy = 1'b0;
        idle_run = 0;
        clear_log();
        test_reset();
        test_single();
        test_fairness();
        test_rerequest();
        test_timeout();
        test_integrity();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
